// File: rtl/ram_burst_pkg.sv
// Shared definitions for the RAM burst reader.
// Contents: burst FSM state type, output buffer depth, length saturation
// helper for a given RAM address width.
package ram_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned BUF_DEPTH = 2;

  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned MAX_LEN = 2 ** DEF_ADDR_WIDTH;

  // Largest burst length for a RAM of 2**aw words.
  function automatic int unsigned max_len(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Small FIFO holding stream bytes between the RAM read port and the
// valid/ready output.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, push_data     write one entry
//   pop                 remove the head entry
//   head_data           current head entry
//   occupancy           number of stored entries
//   full, empty         occupancy flags
module stream_skid_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy,
  output logic                          full,
  output logic                          empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      count;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];
  assign occupancy = count;
  assign full      = (count == OCC_W'(DEPTH));
  assign empty     = (count == '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && empty));

endmodule

// File: rtl/ram_burst_reader.sv
// Reads a burst of consecutive bytes from a block RAM with a 1-cycle
// registered read port and presents them as a valid/ready byte stream.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start, start_addr, length   burst command (sampled in IDLE only)
//   busy, done                  burst in progress / completion pulse
//   mem_r_enable, mem_r_addr    RAM read request
//   mem_r_data                  RAM read data (cycle after request)
//   m_valid, m_ready, m_data,   output byte stream
//   m_last
module ram_burst_reader
  import ram_burst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_r_enable,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  input  logic [DATA_WIDTH-1:0] mem_r_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(max_len(ADDR_WIDTH));
  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);

  state_t               state;
  state_t               state_next;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [LEN_W-1:0]     issue_cnt;
  logic [LEN_W-1:0]     out_cnt;
  logic [LEN_W-1:0]     len_sat;
  logic                 inflight;
  logic                 done_q;
  logic                 done_next;
  logic                 issue;
  logic                 pop;
  logic                 accept;
  logic [OCC_W-1:0]     occ;
  logic [OCC_W:0]       pending;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Credit check: buffered plus in-flight bytes, less the byte leaving this
  // cycle, must leave room for the byte requested now.
  always_comb begin
    len_sat    = (length > LEN_MAX) ? LEN_MAX : length;
    pop        = m_valid & m_ready;
    pending    = (OCC_W+1)'(occ) + (OCC_W+1)'(inflight);
    issue      = (state == RUN) && (issue_cnt != '0) &&
                 (pending < ((OCC_W+1)'(BUF_DEPTH) + (OCC_W+1)'(pop)));
    accept     = (state == IDLE) && start && (len_sat != '0);
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_sat != '0) state_next = RUN;
          else               done_next  = 1'b1;
        end
      end
      RUN: begin
        if (issue && issue_cnt == LEN_W'(1)) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && out_cnt == LEN_W'(1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= done_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      issue_cnt <= '0;
      out_cnt   <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (accept) begin
        rd_ptr    <= start_addr;
        issue_cnt <= len_sat;
        out_cnt   <= len_sat;
      end else begin
        if (issue) begin
          rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
          issue_cnt <= issue_cnt - LEN_W'(1);
        end
        if (pop) begin
          out_cnt <= out_cnt - LEN_W'(1);
        end
      end
    end
  end

  stream_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (mem_r_data),
    .pop       (pop),
    .head_data (m_data),
    .occupancy (occ),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign busy         = (state != IDLE);
  assign done         = done_q;
  assign mem_r_enable = issue;
  assign mem_r_addr   = rd_ptr;
  assign m_valid      = !fifo_empty;
  assign m_last       = m_valid && (out_cnt == LEN_W'(1));

endmodule

// File: tb/tb_ram_burst_reader.sv
module tb_ram_burst_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] length;
  logic       busy;
  logic       done;
  logic       mem_r_enable;
  logic [3:0] mem_r_addr;
  logic [7:0] mem_r_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  ram_burst_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_addr   (start_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .mem_r_enable (mem_r_enable),
    .mem_r_addr   (mem_r_addr),
    .mem_r_data   (mem_r_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, mem[i] = A0 + i
  logic [7:0] ram [16];
  initial begin
    mem_r_data = '0;
    for (int i = 0; i < 16; i++) ram[i] = 8'(8'hA0 + i);
  end
  always @(posedge clk) if (mem_r_enable) mem_r_data <= ram[mem_r_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor, relative to the start cycle t0
  int         t0 = 0;
  bit         mon_en = 1'b0;
  logic [7:0] d_q [$];
  bit         l_q [$];
  int         c_q [$];
  int         dn_q [$];
  bit         b_q [$];
  int         rd_early, rd_total, v_cnt, stall_bad;
  logic [7:0] hold_exp = 8'hA0;

  task automatic clear_mon();
    d_q.delete(); l_q.delete(); c_q.delete(); dn_q.delete(); b_q.delete();
    rd_early = 0; rd_total = 0; v_cnt = 0; stall_bad = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      int rel;
      rel = cyc - t0;
      if (m_valid && m_ready) begin
        d_q.push_back(m_data);
        l_q.push_back(m_last);
        c_q.push_back(rel);
      end
      if (mem_r_enable) begin
        rd_total++;
        if (rel <= 8) rd_early++;
      end
      if (m_valid) v_cnt++;
      if (done) dn_q.push_back(rel);
      b_q.push_back(busy);
      if (rel >= 3 && rel <= 8 && (!m_valid || m_data !== hold_exp)) stall_bad++;
    end
  end

  // Drive one burst for ncyc cycles; m_ready low on cycles s0..s1,
  // a second start with a different address on cycle mid.
  task automatic run(input logic [3:0] a, input logic [4:0] l,
                     input int s0, input int s1, input int mid, input int ncyc);
    clear_mon();
    @(posedge clk); #1;
    t0 = cyc;
    mon_en = 1'b1;
    for (int r = 0; r < ncyc; r++) begin
      start      = (r == 0) || (r == mid);
      start_addr = (r == mid) ? a + 4'd7 : a;
      length     = (r == mid) ? 5'd3 : l;
      m_ready    = !(r >= s0 && r <= s1);
      @(posedge clk); #1;
    end
    start  = 1'b0;
    mon_en = 1'b0;
  endtask

  task automatic check_burst(input string tag, input logic [3:0] a, input int n,
                             input int c0, input int dc);
    check($sformatf("%s_count", tag), d_q.size(), n);
    for (int i = 0; i < n && i < d_q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), int'(d_q[i]), 8'hA0 + ((int'(a) + i) % 16));
      check($sformatf("%s_cyc%0d", tag, i), c_q[i], c0 + i);
      check($sformatf("%s_last%0d", tag, i), int'(l_q[i]), (i == n - 1) ? 1 : 0);
    end
    check($sformatf("%s_done_cnt", tag), dn_q.size(), 1);
    if (dn_q.size() > 0) check($sformatf("%s_done_cyc", tag), dn_q[0], dc);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ren", mem_r_enable, 0);
    check("rst_raddr", mem_r_addr, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_last", m_last, 0);
    @(negedge clk) rst = 1'b0;

    // basic burst
    run(4'd2, 5'd4, -1, -1, -1, 12);
    check_burst("basic", 4'd2, 4, 3, 7);
    check("basic_reads", rd_total, 4);
    check("basic_busy0", int'(b_q[0]), 0);
    check("basic_busy1", int'(b_q[1]), 1);
    check("basic_busy6", int'(b_q[6]), 1);
    check("basic_busy7", int'(b_q[7]), 0);

    // address wrap
    run(4'd14, 5'd4, -1, -1, -1, 12);
    check_burst("wrap", 4'd14, 4, 3, 7);

    // backpressure on cycles 3..8
    hold_exp = 8'hA0;
    run(4'd0, 5'd5, 3, 8, -1, 20);
    check_burst("stall", 4'd0, 5, 9, 14);
    check("stall_reads_early", rd_early, 2);
    check("stall_hold", stall_bad, 0);
    check("stall_reads", rd_total, 5);

    // zero length
    run(4'd3, 5'd0, -1, -1, -1, 6);
    check("zero_reads", rd_total, 0);
    check("zero_valid", v_cnt, 0);
    check("zero_done_cnt", dn_q.size(), 1);
    if (dn_q.size() > 0) check("zero_done_cyc", dn_q[0], 1);
    check("zero_busy", b_q.sum() with (int'(item)), 0);

    // saturation to 16
    run(4'd5, 5'd20, -1, -1, -1, 25);
    check_burst("sat", 4'd5, 16, 3, 19);
    check("sat_reads", rd_total, 16);

    // start while busy ignored
    run(4'd2, 5'd4, -1, -1, 2, 12);
    check_burst("midstart", 4'd2, 4, 3, 7);
    check("midstart_reads", rd_total, 4);

    // reset mid-burst, asserted between edges
    clear_mon();
    @(posedge clk); #1;
    t0 = cyc; mon_en = 1'b1;
    start = 1'b1; start_addr = 4'd8; length = 5'd6; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("prerst_valid", m_valid, 1);
    check("prerst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_valid", m_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ren", mem_r_enable, 0);
    check("midrst_data", m_data, 0);
    check("midrst_last", m_last, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1 mon_en = 1'b0;
    check("midrst_nodone", dn_q.size(), 0);

    run(4'd1, 5'd3, -1, -1, -1, 10);
    check_burst("postrst", 4'd1, 3, 3, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
